ahb_mac_array: RTL
==================

# ahb_mac_array

Parametrised multi-channel AHB-Lite multiply-accumulate slave; successor to the single-channel MAC peripheral on the Cortex-M3 AHB matrix. Provides NCH independent signed accumulators with a two-stage multiply/accumulate pipeline, optional saturation, and sticky per-channel overflow. Read-data stalls on accumulator reads guarantee software never sees a stale result, so firmware for the MFCC/CNN kernels needs no polling.

## Interface
- DW, 16: signed operand width (A, B taken from hwdata[DW-1:0]); 2..16
- AW, 40: signed accumulator width; 2*DW+1..64
- NCH, 4: number of channels; 1..8
- hclk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- hready_i  in  1  AHB bus ready
- hsel  in  1  slave select
- hwrite  in  1  write/read
- htrans  in  2  transfer type; NONSEQ/SEQ (bit1=1) start a transfer
- haddr  in  16  byte address
- hwdata  in  32  write data (data phase)
- hresp  out  1  always 0 (OKAY)
- hready_o  out  1  slave ready; low only for accumulator-read stalls
- hrdata  out  32  read data, valid when hready_o=1 in data phase

## Operation
- Address phase accepted when hsel & htrans[1] & hready_i; haddr[11:2], hwrite registered for the data phase.
- Register map (word-aligned; unmapped: read 0, write ignored):
  - 0x000 CTRL RW: bit0 CLR_ALL (write 1: clear every accumulator and overflow flag, reads 0), bit1 SAT_EN.
  - 0x004 STATUS: bits[NCH-1:0] sticky overflow (write 1 to clear), bit16 BUSY (pipeline non-empty), read-only otherwise.
  - 0x008 ID RO: {8'hA5, NCH[7:0], DW[7:0], AW[7:0]}.
  - 0x100+0x10*c, channel c: +0x0 A (RW, DW bits, read sign-extended); +0x4 B (write-only, triggers MAC, reads 0); +0x8 ACC_LO (RO acc[31:0]; any write clears acc[c] and ovf[c]); +0xC ACC_HI (RO acc[AW-1:32] sign-extended to 32 bits; 0-padded sign ext if AW<=32).
- MAC on B write to channel c: stage 1 prod <= sext(A[c]) * sext(hwdata[DW-1:0]) (2*DW bits, tagged with c); stage 2 sum = acc[c] + sext(prod) at AW+1 bits.
- Overflow when sum out of AW-bit signed range: ovf[c] set; SAT_EN=1 clamps to +2^(AW-1)-1 / -2^(AW-1); SAT_EN=0 wraps (keep low AW bits).
- Back-to-back B writes (one per cycle, same or different channel) fully pipelined, no stall; stage 2 reads the just-updated acc[c].
- A write in the cycle after a B write does not affect the in-flight product (A sampled in stage 1).
- Clear precedence: CLR_ALL or ACC_LO write to channel c on the same edge as a stage-2 update to c -> clear wins, product discarded; CLR_ALL also flushes stage 1.
- Reset (any time, incl. mid-pipeline): all accumulators, A regs, ovf, SAT_EN, pipeline valids = 0; hready_o=1, hrdata=0, hresp=0.

## Timing
- Writes: zero wait states; register updates at the data-phase-ending edge.
- B write data phase in cycle T: product registered at end of T, acc[c] updated at end of T+1.
- ACC_LO/ACC_HI/STATUS-read data phase: hready_o=0 while any stage valid (max 2 cycles), then hready_o=1 with hrdata from the drained accumulators. A new B write cannot enter during a stall.
- Other reads: zero wait, hrdata combinational from registers in the data phase.
- hready_o=1 whenever no read stall is active, including idle.

## Test plan
- Reset: after rst_n deassert, hready_o=1, hrdata=0, all ACC reads 0, ID reads 0xA5041028 (defaults).
- Ch0 A=3, B=-5, B=7 back-to-back; read ACC_LO immediately -> one stall cycle, value 0x00000006; ACC_HI 0x0.
- Ch1 A=0x7FFF, ACC preloaded near max by repeated B=0x7FFF, SAT_EN=1 -> ACC saturates at 0x7F_FFFFFFFF, STATUS bit1=1; write STATUS 0x2 -> bit clears; SAT_EN=0 repeat -> wraps negative.
- Interleaved channels: B writes to ch0,ch2,ch0 consecutive cycles -> ch0 and ch2 hold independent correct sums.
- CLR_ALL issued the cycle after a B write -> all ACC read 0, pending product discarded.
- Assert rst_n low mid-pipeline and mid-stall -> outputs return to reset values immediately, ACC reads 0 afterwards.

Source files
------------

// File: rtl/ahb_mac_array.sv
// ahb_mac_array: multi-channel AHB-Lite multiply-accumulate slave.
// Each channel holds an operand A and a signed accumulator. A write to B
// launches A*B into a one-register multiply stage. The product is then added
// into the channel accumulator on the following edge.
// Accumulator/STATUS reads stall while a product is still in flight.
module ahb_mac_array #(
  parameter int DW  = 16,
  parameter int AW  = 40,
  parameter int NCH = 4
) (
  input  logic        hclk,
  input  logic        rst_n,
  input  logic        hready_i,
  input  logic        hsel,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [15:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hresp,
  output logic        hready_o,
  output logic [31:0] hrdata
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW = 2 * DW;
  localparam int SW = AW + 1;
  localparam logic [NCH-1:0] CH_ONE  = NCH'(1'b1);
  localparam logic [AW-1:0]  ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0]  ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [31:0]    ID_VAL  = {8'hA5, 8'(NCH), 8'(DW), 8'(AW)};

  // Data-phase state captured from the address phase
  logic           dp_valid_r;
  logic           dp_write_r;
  logic [9:0]     dp_idx_r;
  logic           accept_s;

  // Architectural registers
  logic           sat_en_r;
  logic [DW-1:0]  a_r   [NCH];
  logic [AW-1:0]  acc_r [NCH];
  logic           ovf_r [NCH];
  logic [NCH-1:0] ovf_vec_s;

  // Multiply stage
  logic           s1_valid_r;
  logic [CW-1:0]  s1_ch_r;
  logic [PW-1:0]  s1_prod_r;
  logic [DW-1:0]  a_sel_s;
  logic [PW-1:0]  a_ext_s;
  logic [PW-1:0]  b_ext_s;

  // Decode
  logic           wr_s;
  logic           rd_s;
  logic           is_ctrl_s;
  logic           is_status_s;
  logic           is_id_s;
  logic [2:0]     ch_full_s;
  logic           ch_ok_s;
  logic [CW-1:0]  ch_s;
  logic [1:0]     reg_k_s;
  logic [NCH-1:0] ch_sel_vec_s;
  logic           wr_ctrl_s;
  logic           clr_all_s;
  logic           wr_status_s;
  logic           mac_start_s;
  logic [NCH-1:0] wr_a_vec_s;
  logic [NCH-1:0] acc_clr_vec_s;
  logic           stall_rd_s;

  // Accumulate stage
  logic [AW-1:0]  acc_cur_s;
  logic [SW-1:0]  sum_s;
  logic           ovf_s;
  logic [AW-1:0]  acc_new_s;
  logic [NCH-1:0] upd_vec_s;

  // Read path
  logic [31:0]    rd_data_s;
  logic [63:0]    acc_ext_s;

  logic           unused_s;
  assign unused_s = ^{haddr[15:12], haddr[1:0], htrans[0], hwdata};

  assign accept_s = hsel & htrans[1] & hready_i;

  // Capture address-phase controls whenever the bus advances.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_idx_r   <= 10'd0;
    end else if (hready_i) begin
      dp_valid_r <= accept_s;
      dp_write_r <= hwrite;
      dp_idx_r   <= haddr[11:2];
    end
  end

  // Decode the data-phase word index into register strobes.
  always_comb begin
    wr_s          = dp_valid_r & dp_write_r;
    rd_s          = dp_valid_r & ~dp_write_r;
    is_ctrl_s     = (dp_idx_r == 10'd0);
    is_status_s   = (dp_idx_r == 10'd1);
    is_id_s       = (dp_idx_r == 10'd2);
    ch_full_s     = dp_idx_r[4:2];
    ch_ok_s       = (dp_idx_r[9:5] == 5'b00010) && ({29'd0, ch_full_s} < NCH);
    ch_s          = CW'(ch_full_s);
    reg_k_s       = dp_idx_r[1:0];
    ch_sel_vec_s  = {NCH{1'b0}};
    if (ch_ok_s) begin
      ch_sel_vec_s = CH_ONE << ch_s;
    end else begin
      ch_sel_vec_s = {NCH{1'b0}};
    end
    wr_ctrl_s     = wr_s & is_ctrl_s;
    clr_all_s     = wr_ctrl_s & hwdata[0];
    wr_status_s   = wr_s & is_status_s;
    mac_start_s   = wr_s & ch_ok_s & (reg_k_s == 2'd1);
    wr_a_vec_s    = (wr_s && (reg_k_s == 2'd0)) ? ch_sel_vec_s : {NCH{1'b0}};
    acc_clr_vec_s = ((wr_s && (reg_k_s == 2'd2)) ? ch_sel_vec_s : {NCH{1'b0}})
                    | {NCH{clr_all_s}};
    stall_rd_s    = rd_s & (is_status_s | (ch_ok_s & reg_k_s[1]));
  end

  // Operand selection for the multiply stage (A sampled with B).
  always_comb begin
    a_sel_s = a_r[ch_s];
    a_ext_s = PW'($signed(a_sel_s));
    b_ext_s = PW'($signed(hwdata[DW-1:0]));
  end

  // Multiply stage register; CLR_ALL drops anything in flight.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_ch_r    <= {CW{1'b0}};
      s1_prod_r  <= {PW{1'b0}};
    end else if (clr_all_s) begin
      s1_valid_r <= 1'b0;
    end else if (mac_start_s) begin
      s1_valid_r <= 1'b1;
      s1_ch_r    <= ch_s;
      s1_prod_r  <= a_ext_s * b_ext_s;
    end else begin
      s1_valid_r <= 1'b0;
    end
  end

  // Accumulate stage: widen by one bit, detect overflow, saturate or wrap.
  always_comb begin
    acc_cur_s = acc_r[s1_ch_r];
    sum_s     = {acc_cur_s[AW-1], acc_cur_s} + SW'($signed(s1_prod_r));
    ovf_s     = s1_valid_r & (sum_s[AW] != sum_s[AW-1]);
    acc_new_s = sum_s[AW-1:0];
    if (ovf_s && sat_en_r) begin
      acc_new_s = sum_s[AW] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_new_s = sum_s[AW-1:0];
    end
    if (s1_valid_r) begin
      upd_vec_s = CH_ONE << s1_ch_r;
    end else begin
      upd_vec_s = {NCH{1'b0}};
    end
  end

  // Saturation enable lives in CTRL bit 1.
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      sat_en_r <= 1'b0;
    end else if (wr_ctrl_s) begin
      sat_en_r <= hwdata[1];
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Operand A register of this channel.
    always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
        a_r[c] <= {DW{1'b0}};
      end else if (wr_a_vec_s[c]) begin
        a_r[c] <= hwdata[DW-1:0];
      end
    end

    // Accumulator: a clear on the same edge beats the stage-2 update.
    always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
        acc_r[c] <= {AW{1'b0}};
      end else if (acc_clr_vec_s[c]) begin
        acc_r[c] <= {AW{1'b0}};
      end else if (upd_vec_s[c]) begin
        acc_r[c] <= acc_new_s;
      end
    end

    // Sticky overflow: cleared with the accumulator, W1C through STATUS.
    always_ff @(posedge hclk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_r[c] <= 1'b0;
      end else if (acc_clr_vec_s[c]) begin
        ovf_r[c] <= 1'b0;
      end else begin
        ovf_r[c] <= (ovf_r[c] & ~(wr_status_s & hwdata[c])) | (upd_vec_s[c] & ovf_s);
      end
    end

    assign ovf_vec_s[c] = ovf_r[c];
  end

  // Read-data multiplexer for the current data phase.
  always_comb begin
    rd_data_s = 32'd0;
    acc_ext_s = 64'($signed(acc_r[ch_s]));
    if (rd_s) begin
      if (is_ctrl_s) begin
        rd_data_s = {30'd0, sat_en_r, 1'b0};
      end else if (is_status_s) begin
        rd_data_s = {15'd0, s1_valid_r, 16'(ovf_vec_s)};
      end else if (is_id_s) begin
        rd_data_s = ID_VAL;
      end else if (ch_ok_s) begin
        case (reg_k_s)
          2'd0:    rd_data_s = 32'($signed(a_r[ch_s]));
          2'd2:    rd_data_s = acc_ext_s[31:0];
          2'd3:    rd_data_s = acc_ext_s[63:32];
          default: rd_data_s = 32'd0;
        endcase
      end else begin
        rd_data_s = 32'd0;
      end
    end else begin
      rd_data_s = 32'd0;
    end
  end

  assign hrdata   = rd_data_s;
  assign hready_o = ~(stall_rd_s & s1_valid_r);
  assign hresp    = 1'b0;

endmodule
